// File: rtl/bist_pkg.sv
// bist_pkg: shared types, polynomials and helpers for the 4x4 BIST controller
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [3:0] MISR_POLY = 4'h3;
  localparam int CNT_W = 8;
  function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] y);
    return {m[2:0], 1'b0} ^ (m[3] ? MISR_POLY : 4'h0) ^ y;
  endfunction
endpackage

// File: rtl/bist_misr4.sv
// bist_misr4: 4-bit MISR on x^4+x+1 with seed load and absorb enable
module bist_misr4
  import bist_pkg::*;
#(
  parameter logic [3:0] SEED = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] sig,
  output logic [3:0] nxt
);
  assign nxt = misr_step(sig, d);
  // seed on reset or load, otherwise absorb when enabled
  always_ff @(posedge clk)
    if (rst || ld) sig <= SEED;
    else if (en) sig <= nxt;
endmodule

// File: rtl/bist_ctrl_4x4.sv
// bist_ctrl_4x4: LFSR-driven BIST with MISR compaction; BIST_CAPTURE_PIPE_EN registers y before absorb
module bist_ctrl_4x4
  import bist_pkg::*;
#(
  parameter int         N_PATTERNS = 255,
  parameter logic [7:0] SEED       = 8'hA5,
  parameter logic [3:0] MISR_SEED  = 4'h0,
  parameter logic [3:0] GOLDEN     = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig
);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
`ifdef BIST_CAPTURE_PIPE_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);
`endif
  state_t state, state_nx;
  logic [7:0] lfsr;
  logic [CNT_W-1:0] cnt;
  logic [3:0] misr_d, misr_nxt;
  logic run, last, go, absorb;
  assign run  = state == RUN;
  assign last = cnt == LAST;
  assign go   = !run && start;
  assign busy = run;
  assign done = state == DONE;
  assign a    = lfsr[3:0];
  assign b    = lfsr[7:4];
`ifdef BIST_CAPTURE_PIPE_EN
  logic [3:0] y_q;
  // one-stage capture of the circuit response; first RUN edge only fills it
  always_ff @(posedge clk)
    if (rst) y_q <= 4'h0;
    else y_q <= y;
  assign misr_d = y_q;
  assign absorb = run && cnt != '0;
`else
  assign misr_d = y;
  assign absorb = run;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: RUN ends on the final absorb edge, start accepted outside RUN
  always_comb begin
    state_nx = state;
    state_nx = run ? (last ? DONE : RUN) : (start ? RUN : state);
  end
  // pattern generator and pattern counter
  always_ff @(posedge clk)
    if (rst || go) begin
      lfsr <= SEED_EFF;
      cnt  <= '0;
    end else if (run) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      cnt  <= cnt + 1'b1;
    end
  // verdict captured from the signature being formed on the final edge
  always_ff @(posedge clk)
    if (rst || go) pass <= 1'b0;
    else if (run && last) pass <= misr_nxt == GOLDEN;
  bist_misr4 #(.SEED(MISR_SEED)) u_misr (
    .clk(clk), .rst(rst), .ld(go), .en(absorb), .d(misr_d), .sig(sig), .nxt(misr_nxt)
  );
endmodule

// File: doc/bist_ctrl_4x4.md
# bist_ctrl_4x4

- Self-contained built-in self-test controller for the 4-bit-a / 4-bit-b / 4-bit-y gate-level test circuits used in ECO regression.
- Drives the circuit's a and b inputs from an 8-bit maximal-length LFSR.
- Compacts the circuit's y outputs into a 4-bit MISR signature and compares it against a golden value.
- Lets a pre-ECO and a post-ECO netlist be checked for functional equivalence by signature alone.

## Interface
- N_PATTERNS, 255, patterns per run; legal range 1..255.
- SEED, 8'hA5, LFSR start state; 0 is illegal and is forced to 8'h01.
- MISR_SEED, 4'h0, signature start state.
- GOLDEN, 4'h0, expected final signature.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- a  out  4  stimulus to the circuit under test; registered; equals LFSR[3:0].
- b  out  4  stimulus to the circuit under test; registered; equals LFSR[7:4].
- y  in  4  response from the circuit under test, which is combinational.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  valid while done is high; 1 when sig == GOLDEN.
- sig  out  4  current MISR state.

## Operation
- States: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - LFSR holds the effective seed, MISR holds MISR_SEED, and the counter is 0.
  - start=1 moves to RUN.
- RUN, on each edge:
  - The MISR absorbs y.
  - The LFSR advances: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - The counter increments.
  - When the counter reaches N_PATTERNS, go to DONE; this is the final absorb edge.
- MISR update, polynomial x^4+x+1:
  - n[0]=m[3]^y[0]
  - n[1]=m[0]^m[3]^y[1]
  - n[2]=m[1]^y[2]
  - n[3]=m[2]^y[3]
- DONE:
  - The LFSR, MISR and sig freeze.
  - pass is registered on DONE entry from the final MISR value.
  - start=1 reloads the LFSR and MISR seeds, clears done and pass, and re-enters RUN.
- start is ignored in RUN.
- Counter is 8 bits. The LFSR period is 255 and N_PATTERNS is at most 255, so no pattern repeats within a run.

## Timing
- Reset values:
  - a=SEED[3:0], b=SEED[7:4]
  - busy=0, done=0, pass=0
  - sig=MISR_SEED
- rst mid-run aborts the run on that same edge and returns all outputs to their reset values.
- Edge E0 samples start=1. busy is high from E0 to E(N_PATTERNS). done and pass are valid after E(N_PATTERNS).
- Pattern k is presented on a/b during RUN cycle k and absorbed at the edge that ends that cycle. Pattern 0 is the seed.
- Latency from start to done is N_PATTERNS cycles.
- start and rst on the same edge: rst wins.

## Configuration
- BIST_CAPTURE_PIPE_EN defined:
  - y is registered into y_q, and the MISR absorbs y_q.
  - RUN lasts N_PATTERNS+1 cycles.
  - Absorption is suppressed on the first RUN edge and then continues for N_PATTERNS edges.
  - busy is high for N_PATTERNS+1 cycles.
  - The final signature is identical to the undefined case.
- Undefined: direct capture as above, and RUN lasts N_PATTERNS cycles.

## Structure
- Package bist_pkg:
  - State enum: IDLE, RUN, DONE.
  - LFSR tap mask 8'hB8.
  - MISR polynomial constant.
  - 8-bit counter width.
- One sub-module, bist_misr4, holds the 4-bit MISR register with load-seed and absorb-enable inputs.
- The LFSR, counter and FSM stay in the top module.

## Test plan
- LFSR sequence: SEED=8'hA5, start pulse, y tied to 0. Required (b,a):
  - RUN cycle 0: (A,5)
  - cycle 1: (4,A), LFSR 8'h4A
  - cycle 2: (9,5), LFSR 8'h95
- MISR, y held at 4'hF, MISR_SEED=0:
  - N_PATTERNS=1: sig=4'hF.
  - N_PATTERNS=2: sig=4'h2; with GOLDEN=4'h2, pass=1.
- Mismatch: y held at 0 with GOLDEN=4'h3. Required: sig=0, done=1, pass=0. done and pass hold for 10 idle cycles.
- Reset mid-run: N_PATTERNS=100, rst at RUN cycle 50. Required on the next cycle: busy=0, done=0, a=5, b=A, sig=0. A subsequent start gives the same signature as a clean run.
- Restart from DONE: start in DONE. Required: done=0 on the next cycle, the seed is re-presented, and the signature is identical to the first run. start pulses issued during RUN do not change the signature or the cycle count.
- With BIST_CAPTURE_PIPE_EN, bench against the combinational 4-in/4-in/4-out test circuit, N_PATTERNS=255. Required:
  - busy is high for exactly 256 cycles.
  - The signature equals the non-pipelined build's signature.
